// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - multi-port register file with busy scoreboard and write-to-read bypass
//
// Purpose: NUM_READ synchronous operand read ports, one write port and a debug read
// port over 2**ADDR_WIDTH registers. A per-register busy bit is set by a reservation
// and cleared by the matching writeback. Each read port reports its operand's busy
// state as seen after the current edge's updates.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   write_enable/_address/write_data_in   writeback port (clears busy)
//   reserve_enable/_address               marks a register busy
//   read_address          packed NUM_READ addresses, slice k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//   data_out, data_busy   registered read data (bypassed) and busy flag per port
//   read_address_debug, data_out_debug    registered debug read, pre-write value
//   busy_vector           live scoreboard, bit i = register i busy
module reg_file_scoreboard #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_READ       = 3,
  parameter int ZERO_REG       = 1,
  parameter int RESET_TO_INDEX = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           write_enable,
  input  logic [ADDR_WIDTH-1:0]          write_address,
  input  logic [DATA_WIDTH-1:0]          write_data_in,
  input  logic                           reserve_enable,
  input  logic [ADDR_WIDTH-1:0]          reserve_address,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
  output logic [NUM_READ-1:0]            data_busy,
  input  logic [ADDR_WIDTH-1:0]          read_address_debug,
  output logic [DATA_WIDTH-1:0]          data_out_debug,
  output logic [2**ADDR_WIDTH-1:0]       busy_vector
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0]            busy;
  logic [NUM_REGS-1:0]            busy_next;
  logic                           write_ok;
  logic                           reserve_ok;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data_next;
  logic [NUM_READ-1:0]            read_busy_next;

  // Register i resets to i (truncated to DATA_WIDTH) or to zero; r0 stays zero when hardwired.
  function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
    if ((ZERO_REG != 0 && idx == 0) || RESET_TO_INDEX == 0)
      return '0;
    return DATA_WIDTH'($unsigned(idx));
  endfunction

  // Accesses to a hardwired r0 are dropped before they reach any state.
  assign write_ok   = write_enable   && !(ZERO_REG != 0 && write_address   == '0);
  assign reserve_ok = reserve_enable && !(ZERO_REG != 0 && reserve_address == '0);

  // Reservation is applied after the write clear so a same-address reserve wins.
  always_comb begin
    busy_next = busy;
    if (write_ok)
      busy_next[write_address] = 1'b0;
    if (reserve_ok)
      busy_next[reserve_address] = 1'b1;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    logic                  zero_hit;

    assign addr     = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);

    assign read_data_next[k*DATA_WIDTH +: DATA_WIDTH] =
      zero_hit                              ? '0            :
      (write_ok && write_address == addr)   ? write_data_in :
                                              regs[addr];
    assign read_busy_next[k] = zero_hit ? 1'b0 : busy_next[addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= reset_value(i);
      busy           <= '0;
      data_out       <= '0;
      data_busy      <= '0;
      data_out_debug <= '0;
    end else begin
      if (write_ok)
        regs[write_address] <= write_data_in;
      busy           <= busy_next;
      data_out       <= read_data_next;
      data_busy      <= read_busy_next;
      // Debug view deliberately shows the pre-write contents.
      data_out_debug <= regs[read_address_debug];
    end
  end

  assign busy_vector = busy;

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised multi-port register file for the M1 datapath. It provides NUM_READ synchronous read ports, one write port and a debug read port. A per-register busy scoreboard lets issue logic reserve a destination register and see, per read port, whether each operand is still pending. Same-cycle write-to-read bypass means a writeback is visible to a read issued in the same cycle.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH
NUM_READ, 3, number of operand read ports (1..8)
ZERO_REG, 1, 1 = register 0 is hardwired to zero; writes and reservations to it are ignored
RESET_TO_INDEX, 1, 1 = register i resets to value i (zero-extended, truncated to DATA_WIDTH); 0 = resets to zero

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
write_enable  in  1  writeback strobe
write_address  in  ADDR_WIDTH  writeback destination
write_data_in  in  DATA_WIDTH  writeback data
reserve_enable  in  1  marks reserve_address busy (pending producer)
reserve_address  in  ADDR_WIDTH  register to reserve
read_address  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
data_out  out  NUM_READ*DATA_WIDTH  packed registered read data, same slicing
data_busy  out  NUM_READ  registered busy flag per read port
read_address_debug  in  ADDR_WIDTH  debug read address
data_out_debug  out  DATA_WIDTH  registered debug read data (no bypass)
busy_vector  out  2**ADDR_WIDTH  current scoreboard, bit i = register i busy

Behaviour:
- Reset (asynchronous, active-high):
  - register i <- i when RESET_TO_INDEX=1, else 0; register 0 is always 0 when ZERO_REG=1.
  - All busy bits <- 0.
  - data_out, data_busy and data_out_debug <- 0.
  - Reset asserted mid-operation discards any in-flight write or reservation in that cycle.
- Write: on rising edge with write_enable=1, register[write_address] <- write_data_in and busy[write_address] <- 0. Ignored for address 0 when ZERO_REG=1.
- Reserve: on rising edge with reserve_enable=1, busy[reserve_address] <- 1. Ignored for address 0 when ZERO_REG=1.
- Reserve and write to the same address in the same cycle: data is written and busy ends at 1 (the new producer wins).
- Reserve and write to different addresses in the same cycle: both take effect.
- Read ports:
  - Latency is 1 cycle. On rising edge, data_out slice k <- register[read_address k].
  - Bypass: if write_enable=1 and write_address equals read_address k (and is not a suppressed address 0), slice k <- write_data_in instead.
  - data_busy[k] <- next-state busy bit of read_address k, i.e. after this edge's write and reserve updates. A read that coincides with a writeback reports not-busy unless the same address is also reserved that edge.
  - Address 0 with ZERO_REG=1 always reads 0 with data_busy=0.
  - Multiple ports may read the same address; each receives identical data.
- Debug port: data_out_debug <- register[read_address_debug] on rising edge, pre-write value, no bypass. Intended for board display.
- busy_vector: direct view of the scoreboard flops, updated on the edge.
- Write of the largest index (2**ADDR_WIDTH-1) requires no special handling; there is no address wrap.
- Reset values wider than DATA_WIDTH are truncated.

Test Plan:
1. Reset then read all addresses on ports 0..2 -> data_out slice k equals its address one cycle later; busy_vector=0; data_busy=0.
2. Write 0xDEADBEEF to r7 while port 1 reads r7 in the same cycle -> next cycle port 1 = 0xDEADBEEF (bypass); debug port reading r7 that cycle = 7.
3. Reserve r9; next cycle port 0 reads r9 -> data_busy[0]=1 and data=9; then write 0x55 to r9 with port 0 reading r9 -> data=0x55, data_busy[0]=0, busy_vector[9]=0.
4. Same edge: reserve r4 and write 0x11 to r4 -> register r4=0x11, busy_vector[4]=1; a read of r4 on that edge returns 0x11 with data_busy=1.
5. ZERO_REG=1: write 0xFFFFFFFF and reserve to r0 -> r0 reads 0, busy_vector[0]=0; second config RESET_TO_INDEX=0 -> all registers read 0 after reset.
6. Reserve r3 and write 0x77 to r5, then assert reset asynchronously mid-cycle (between edges) -> data_out, data_busy, data_out_debug and busy_vector go to 0 immediately; after release, r5 reads 5 and r3 is not busy.
